// File: rtl/instr_fetch_mem.sv
// Instruction memory with a one-deep registered fetch-group output, jump redirect and program load port.
// Optional build macro IMEM_ALIGN_EN masks slots that cross the FETCH_W-aligned group boundary.
module instr_fetch_mem #(
  parameter int FETCH_W = 4,
  parameter int DEPTH   = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [31:0]          req_addr,
  output logic                 req_ready,
  input  logic                 jump_valid,
  input  logic [31:0]          jump_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [FETCH_W*32-1:0] out_instr,
  output logic [FETCH_W-1:0]   out_mask,
  input  logic                 load_en,
  input  logic [31:0]          load_addr,
  input  logic [31:0]          load_data,
  output logic                 fsm_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state, state_next;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_idx;
  logic [31:0] load_idx;
  logic        load_in_range;
  logic [31:0] slot_word [FETCH_W];
  logic [FETCH_W-1:0]    slot_ok;
  logic [FETCH_W*32-1:0] instr_next;
  logic [FETCH_W-1:0]    mask_next;
  logic        unused_bits;

  // Handshake: a group moves on an edge where valid && ready are both high;
  // the output side is a one-entry buffer, so req_ready opens when it is empty or draining.
  assign out_valid     = (state == FULL);
  assign req_ready     = !out_valid || out_ready;
  assign accept        = jump_valid || (req_valid && req_ready);
  assign fetch_addr    = jump_valid ? jump_addr : req_addr;
  assign fetch_idx     = {2'b00, fetch_addr[31:2]};
  assign load_idx      = {2'b00, load_addr[31:2]};
  assign load_in_range = load_idx < 32'(DEPTH);
  assign fsm_state     = state;
  assign unused_bits   = ^load_addr[1:0];

  always_comb begin
    state_next = state;
    if (accept) state_next = FULL;
    else if (out_ready) state_next = EMPTY;
  end

  // Slot read path; a load to the same word at this edge is forwarded (write-first).
  always_comb begin
    slot_word  = '{default: '0};
    slot_ok    = '0;
    instr_next = '0;
    mask_next  = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      slot_word[i] = fetch_idx + 32'(i);
      slot_ok[i]   = slot_word[i] < 32'(DEPTH);
`ifdef IMEM_ALIGN_EN
      if ((fetch_idx % 32'(FETCH_W)) + 32'(i) >= 32'(FETCH_W)) slot_ok[i] = 1'b0;
`endif
      if (slot_ok[i]) begin
        mask_next[i] = 1'b1;
        if (load_en && load_idx == slot_word[i]) instr_next[32*i +: 32] = load_data;
        else instr_next[32*i +: 32] = mem[slot_word[i][AW-1:0]];
      end
    end
  end

  // Memory is deliberately outside the reset domain so a program survives reset.
  always_ff @(posedge clk) begin
    if (load_en && load_in_range) mem[load_idx[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_pc    <= '0;
      out_instr <= '0;
      out_mask  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        out_pc    <= fetch_addr;
        out_instr <= instr_next;
        out_mask  <= mask_next;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Randomised and directed bench for instr_fetch_mem against an array/queue reference model.
module tb_instr_fetch_mem;
  localparam int FETCH_W = 4;
  localparam int DEPTH   = 128;
  localparam int W       = 32 + FETCH_W + FETCH_W * 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic [31:0]           req_addr;
  logic                  req_ready;
  logic                  jump_valid;
  logic [31:0]           jump_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_pc;
  logic [FETCH_W*32-1:0] out_instr;
  logic [FETCH_W-1:0]    out_mask;
  logic                  load_en;
  logic [31:0]           load_addr;
  logic [31:0]           load_data;
  logic                  fsm_state;

  int checks = 0;
  int errors = 0;

  logic [31:0]  model_mem [DEPTH];
  logic [W-1:0] exp_q[$];

  instr_fetch_mem #(.FETCH_W(FETCH_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .jump_valid(jump_valid), .jump_addr(jump_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_mask(out_mask),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected group for a byte address, from the current model memory.
  function automatic logic [W-1:0] group_of(input logic [31:0] addr);
    logic [FETCH_W*32-1:0] ins;
    logic [FETCH_W-1:0]    m;
    longint idx;
    bit ok;
    ins = '0;
    m   = '0;
    idx = longint'(addr >> 2);
    for (int i = 0; i < FETCH_W; i++) begin
      ok = (idx + i) < DEPTH;
`ifdef IMEM_ALIGN_EN
      if ((idx % FETCH_W) + i >= FETCH_W) ok = 0;
`endif
      if (ok) begin
        m[i] = 1'b1;
        ins[32*i +: 32] = model_mem[idx + i];
      end
    end
    return {addr, m, ins};
  endfunction

  task automatic check_outputs();
    logic [W-1:0] g;
    check("out_valid", out_valid, exp_q.size() != 0);
    check("fsm_state", fsm_state, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      g = exp_q[0];
      check("out_pc", out_pc, g[W-1 -: 32]);
      check("out_mask", out_mask, g[FETCH_W*32 +: FETCH_W]);
      check("out_instr", out_instr, g[FETCH_W*32-1:0]);
    end
  endtask

  // driver: one clock of stimulus, model update at the edge, then output check
  task automatic step(input bit rv, input logic [31:0] ra, input bit jv, input logic [31:0] ja,
                      input bit ordy, input bit le, input logic [31:0] la, input logic [31:0] ld);
    bit held;
    bit accept;
    @(negedge clk);
    req_valid = rv; req_addr = ra; jump_valid = jv; jump_addr = ja;
    out_ready = ordy; load_en = le; load_addr = la; load_data = ld;
    #1;
    held = exp_q.size() != 0;
    check("req_ready", req_ready, !held || ordy);
    accept = jv || (rv && (!held || ordy));
    @(posedge clk);
    if (le && (la >> 2) < DEPTH) model_mem[la >> 2] = ld;
    if (held && (ordy || jv)) void'(exp_q.pop_front());
    if (accept) exp_q.push_back(group_of(jv ? ja : ra));
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_addr = '0; jump_valid = 0; jump_addr = '0;
    out_ready = 0; load_en = 0; load_addr = '0; load_data = '0;
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    #2;
    reset = 1;
    req_valid = 1; req_addr = '0; jump_valid = 1; jump_addr = 32'h8; out_ready = 1;
    #1;
    exp_q.delete();
    check("rst_valid", out_valid, 1'b0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, '0);
    check("rst_mask", out_mask, '0);
    @(posedge clk);
    #1;
    check("rst_held_valid", out_valid, 1'b0);
    @(negedge clk);
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    logic [3:0] align_mask;
    idle_inputs();
    reset = 1;
    #1;
    check("init_valid", out_valid, 1'b0);
    check("init_pc", out_pc, 32'h0);
    check("init_instr", out_instr, '0);
    check("init_mask", out_mask, '0);
    @(negedge clk);
    reset = 0;

    // program load: random image, then words 0..7 = 0x100+i, then a dropped write
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 1, 32'(i * 4), $urandom);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, 32'(i * 4), 32'h100 + 32'(i));
    step(0, 0, 0, 0, 0, 1, 32'(DEPTH * 4), 32'hBAD);

    // basic fetch
    step(1, 32'h0, 0, 0, 1, 0, 0, 0);
    check("fetch0_pc", out_pc, 32'h0);
    check("fetch0_instr", out_instr, 128'h00000103_00000102_00000101_00000100);
    check("fetch0_mask", out_mask, 4'hF);

    // stall: held group must not move, request refused
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h10, 0, 0, 0, 0, 0, 0);
      check("stall_pc", out_pc, 32'h0);
      check("stall_instr0", out_instr[31:0], 32'h100);
    end
    step(1, 32'h10, 0, 0, 1, 0, 0, 0);
    check("seq_pc", out_pc, 32'h10);
    check("seq_instr", out_instr, 128'h00000107_00000106_00000105_00000104);

    // jump wins over request while stalled
    step(1, 32'h40, 1, 32'h8, 0, 0, 0, 0);
    check("jump_pc", out_pc, 32'h8);
    check("jump_slot0", out_instr[31:0], 32'h102);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    check("jump_req_dropped", out_valid, 1'b0);

    // end of memory
    step(1, 32'h1F8, 0, 0, 1, 0, 0, 0);
    check("edge_mask", out_mask, 4'b0011);
    check("edge_slots23", out_instr[127:64], 64'h0);

    // group alignment
`ifdef IMEM_ALIGN_EN
    align_mask = 4'b0111;
`else
    align_mask = 4'hF;
`endif
    step(1, 32'h4, 0, 0, 1, 0, 0, 0);
    check("align_mask", out_mask, align_mask);

    // write-first forwarding, then a later write must not touch the held group
    step(1, 32'h0, 0, 0, 1, 1, 32'h4, 32'hDEAD);
    check("fwd_slot1", out_instr[63:32], 32'hDEAD);
    step(0, 0, 0, 0, 0, 1, 32'h0, 32'hBEEF);
    check("held_slot0", out_instr[31:0], 32'h100);

    // reset while FULL, memory survives
    reset_mid_cycle();
    step(1, 32'h0, 0, 0, 1, 0, 0, 0);
    check("retain_slot0", out_instr[31:0], 32'hBEEF);
    check("retain_slot1", out_instr[63:32], 32'hDEAD);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) < 7, 32'($urandom_range(0, DEPTH + 3)) << 2,
           $urandom_range(0, 9) == 0, 32'($urandom_range(0, DEPTH + 3)) << 2,
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 4) == 0, 32'($urandom_range(0, DEPTH + 3)) << 2, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter FETCH_W, default 4: instructions per fetch group, 1..8.
REQ-002 SHALL have parameter DEPTH, default 128: 32-bit words stored, power of two.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: sequential fetch request.
REQ-006 SHALL have port req_addr, input, 32 bits: byte address of the sequential group.
REQ-007 SHALL have port req_ready, output, 1 bit: a request is accepted this cycle.
REQ-008 SHALL have port jump_valid, input, 1 bit: redirect request.
REQ-009 SHALL have port jump_addr, input, 32 bits: redirect byte address.
REQ-010 SHALL have port out_valid, output, 1 bit: fetch group held for decode.
REQ-011 SHALL have port out_ready, input, 1 bit: decode consumes the group.
REQ-012 SHALL have port out_pc, output, 32 bits: byte address of slot 0.
REQ-013 SHALL have port out_instr, output, FETCH_W*32 bits: slot i in bits [32i+31:32i].
REQ-014 SHALL have port out_mask, output, FETCH_W bits: bit i set means slot i is valid.
REQ-015 SHALL have port load_en, input, 1 bit: program-load write strobe.
REQ-016 SHALL have port load_addr, input, 32 bits: word-aligned write byte address.
REQ-017 SHALL have port load_data, input, 32 bits: write data.

Function
REQ-018 SHALL decode word index as addr[31:2]; slot i reads word index+i; addr[1:0] SHALL be ignored.
REQ-019 SHALL mark slot i invalid, with instr 32'h0, when index+i >= DEPTH; no wrap-around.
REQ-020 SHALL drive req_ready = !out_valid || out_ready, combinationally.
REQ-021 SHALL have a 1-cycle read latency: a group accepted at edge N is presented from edge N onward as out_valid=1 with registered out_pc, out_instr and out_mask.
REQ-022 SHALL hold out_pc, out_instr and out_mask stable while out_valid=1 and out_ready=0 (FULL state).
REQ-023 SHALL implement states EMPTY and FULL: EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL on out_ready with accept.
REQ-024 SHALL give jump_valid priority over req_valid and out_ready: the jump group SHALL be loaded at the next edge irrespective of state, and the held group SHALL be discarded (flush).
REQ-025 SHALL ignore req_valid when jump_valid=1 in the same cycle.
REQ-026 SHALL write load_data to word load_addr[31:2] at the clock edge when load_en=1; an out-of-range write SHALL be dropped.
REQ-027 SHALL forward load_data to a slot reading the same word at that same edge (write-first).
REQ-028 SHALL NOT alter a group already held in the output register on a later write.

Reset
REQ-029 SHALL, on reset assertion, immediately clear out_valid to 0, out_pc to 0, out_instr to 0 and out_mask to 0, and set state to EMPTY.
REQ-030 SHALL NOT clear the memory array on reset; memory contents SHALL survive reset.
REQ-031 SHALL discard any request or jump presented during reset; first accept occurs at the first edge after deassertion.

Configuration
REQ-032 SHALL, with IMEM_ALIGN_EN defined, additionally mask slots beyond the FETCH_W-aligned group boundary (slot i valid only if (index mod FETCH_W)+i < FETCH_W).
REQ-033 SHALL, without IMEM_ALIGN_EN, apply only the DEPTH limit of REQ-019.

Verification
REQ-034 Bench SHALL cover: load words 0..7 = 0x100+i, req addr 0x0, out_ready=1 -> next cycle out_valid=1, out_pc=0, slots 0x100..0x103, out_mask=4'hF.
REQ-035 Bench SHALL cover: out_ready=0 for 3 cycles after a fill -> outputs unchanged and req_ready=0; then out_ready=1 with req 0x10 -> group 0x104..0x107.
REQ-036 Bench SHALL cover: FULL with out_ready=0, jump_addr 0x8 and req_valid both high -> next cycle out_pc=0x8, slot 0=0x102, sequential request dropped.
REQ-037 Bench SHALL cover: req addr 0x1F8 (index 126), DEPTH=128 -> out_mask=4'b0011, slots 2..3 = 0.
REQ-038 Bench SHALL cover: req addr 0x4 with IMEM_ALIGN_EN defined -> out_mask=4'b0111; without the macro -> 4'hF.
REQ-039 Bench SHALL cover: load_en writes 0xDEAD to word 1 while a fetch of addr 0x0 is accepted at the same edge -> slot 1 = 0xDEAD; reset asserted mid-FULL -> out_valid=0 at once and memory is retained.
